// File: rtl/clock_12h_reader.sv
// clock_12h_reader
//   Takes a coherent snapshot of the 12-hour BCD time bus on request,
//   validates it, and converts it to 24-hour binary hour/min/sec plus a
//   seconds-of-day count. It only reads the time bus and never drives it.
// Ports
//   clk, reset       : rising-edge clock, async active-low reset
//   req              : conversion request, honoured only while idle
//   pm, hh, mm, ss   : time bus (BCD digits, pm flag)
//   busy             : snapshot being processed
//   done             : one-cycle pulse, result/err valid
//   err              : snapshot invalid (held until the next done)
//   hour24, min, sec : binary 24-hour time
//   sod              : seconds since midnight
module clock_12h_reader #(
  parameter bit CLEAR_ON_ERR = 1'b1,
  parameter int SOD_W        = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             pm,
  input  logic [7:0]       hh,
  input  logic [7:0]       mm,
  input  logic [7:0]       ss,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [4:0]       hour24,
  output logic [5:0]       min,
  output logic [5:0]       sec,
  output logic [SOD_W-1:0] sod
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_CONV  = 3'd2;
  localparam logic [2:0] S_ACC_M = 3'd3;
  localparam logic [2:0] S_ACC_S = 3'd4;

  logic [2:0]       state;
  logic [7:0]       snap_hh, snap_mm, snap_ss;
  logic             snap_pm;
  logic [SOD_W-1:0] acc;

  logic             bad;
  logic [4:0]       h_bin;
  logic [5:0]       m_bin, s_bin;
  logic [4:0]       h24;

  // Digit/range check on the snapshot. Once the digits are legal BCD,
  // a plain byte compare against 8'h12 is the same as "hour > 12".
  always_comb begin
    bad = (snap_hh[3:0] > 4'd9) | (snap_hh[7:4] > 4'd1) |
          (snap_hh == 8'h00)    | (snap_hh > 8'h12)     |
          (snap_mm[3:0] > 4'd9) | (snap_mm[7:4] > 4'd5) |
          (snap_ss[3:0] > 4'd9) | (snap_ss[7:4] > 4'd5);
  end

  // BCD to binary. Only used after the range check passed, so the narrow
  // widths cannot overflow (hour <= 12, min/sec <= 59).
  always_comb begin
    h_bin = 5'(snap_hh[7:4]) * 5'd10 + 5'(snap_hh[3:0]);
    m_bin = 6'(snap_mm[7:4]) * 6'd10 + 6'(snap_mm[3:0]);
    s_bin = 6'(snap_ss[7:4]) * 6'd10 + 6'(snap_ss[3:0]);
    // 12 o'clock is hour 0 of its half-day.
    h24   = ((h_bin == 5'd12) ? 5'd0 : h_bin) + (snap_pm ? 5'd12 : 5'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      snap_hh <= 8'h00;
      snap_mm <= 8'h00;
      snap_ss <= 8'h00;
      snap_pm <= 1'b0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      hour24  <= 5'd0;
      min     <= 6'd0;
      sec     <= 6'd0;
      sod     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // All four fields latched on one edge: the counter may tick on
          // this same edge, but every digit comes from the old time.
          if (req) begin
            snap_hh <= hh;
            snap_mm <= mm;
            snap_ss <= ss;
            snap_pm <= pm;
            busy    <= 1'b1;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (bad) begin
            done  <= 1'b1;
            err   <= 1'b1;
            busy  <= 1'b0;
            if (CLEAR_ON_ERR) begin
              hour24 <= 5'd0;
              min    <= 6'd0;
              sec    <= 6'd0;
              sod    <= '0;
            end
            state <= S_IDLE;
          end else begin
            state <= S_CONV;
          end
        end
        S_CONV: begin
          hour24 <= h24;
          min    <= m_bin;
          sec    <= s_bin;
          acc    <= SOD_W'(h24);
          state  <= S_ACC_M;
        end
        S_ACC_M: begin
          // x*60 as x*64 - x*4, avoids a multiplier
          acc   <= (acc << 6) - (acc << 2) + SOD_W'(min);
          state <= S_ACC_S;
        end
        S_ACC_S: begin
          sod   <= (acc << 6) - (acc << 2) + SOD_W'(sec);
          done  <= 1'b1;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_12h_reader.sv
// tb_clock_12h_reader
//   Self-checking bench for clock_12h_reader: directed time cases, error
//   cases, request handling, a running time bus and mid-conversion reset,
//   plus random stimulus, all checked every cycle against a time-arithmetic
//   model of what the reader must report.
module tb_clock_12h_reader;

  logic        clk;
  logic        reset;
  logic        req;
  logic        pm;
  logic [7:0]  hh, mm, ss;
  logic        busy, done, err;
  logic [4:0]  hour24;
  logic [5:0]  min, sec;
  logic [16:0] sod;

  clock_12h_reader #(.CLEAR_ON_ERR(1'b1), .SOD_W(17)) dut (
    .clk(clk), .reset(reset), .req(req), .pm(pm),
    .hh(hh), .mm(mm), .ss(ss),
    .busy(busy), .done(done), .err(err),
    .hour24(hour24), .min(min), .sec(sec), .sod(sod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model state: e counts clock edges since reset release; done_edge is the
  // edge on which the outstanding request reports (-1 = none)
  int e, done_edge;
  bit m_done, m_err, m_busy;
  int m_h, m_m, m_s, m_sod;
  bit p_err;
  int p_h, p_m, p_s, p_sod;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    e = 0; done_edge = -1;
    m_done = 0; m_err = 0; m_busy = 0;
    m_h = 0; m_m = 0; m_s = 0; m_sod = 0;
  endtask

  // what the reader must report for a time bus value
  task automatic model_capture();
    int ht, ho, mt, mo, st, so, hv, mv, sv;
    ht = int'(hh[7:4]); ho = int'(hh[3:0]);
    mt = int'(mm[7:4]); mo = int'(mm[3:0]);
    st = int'(ss[7:4]); so = int'(ss[3:0]);
    hv = ht * 10 + ho; mv = mt * 10 + mo; sv = st * 10 + so;
    p_err = !(ht <= 9 && ho <= 9 && mt <= 9 && mo <= 9 && st <= 9 && so <= 9 &&
              hv >= 1 && hv <= 12 && mv <= 59 && sv <= 59);
    p_h   = (hv % 12) + (pm ? 12 : 0);
    p_m   = mv;
    p_s   = sv;
    p_sod = p_h * 3600 + p_m * 60 + p_s;
  endtask

  task automatic compare();
    check("busy", int'(busy), int'(m_busy));
    check("done", int'(done), int'(m_done));
    check("err",  int'(err),  int'(m_err));
    check("sod",  int'(sod),  m_sod);
    if (m_done) begin
      check("hour24", int'(hour24), m_h);
      check("min",    int'(min),    m_m);
      check("sec",    int'(sec),    m_s);
    end
  endtask

  // one clock: model follows the edge, outputs compared at the falling edge
  task automatic step();
    @(posedge clk);
    if (reset) begin
      e++;
      m_done = 0;
      if (e == done_edge) begin
        m_done = 1;
        m_err  = p_err;
        if (p_err) begin
          m_h = 0; m_m = 0; m_s = 0; m_sod = 0;
        end else begin
          m_h = p_h; m_m = p_m; m_s = p_s; m_sod = p_sod;
        end
      end else if (e > done_edge && req) begin
        model_capture();
        done_edge = e + (p_err ? 1 : 4);
      end
      m_busy = (e < done_edge);
    end
    @(negedge clk);
    compare();
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic set_time(input int d);
    int h;
    h  = d / 3600;
    pm = (h >= 12);
    hh = to_bcd((h % 12 == 0) ? 12 : h % 12);
    mm = to_bcd((d / 60) % 60);
    ss = to_bcd(d % 60);
  endtask

  task automatic idle(input int n);
    req = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  // single request; lat = clock edges from capture to done (-1 on timeout)
  task automatic run_one(input logic [7:0] h, input logic [7:0] m,
                         input logic [7:0] s, input logic p, output int lat);
    idle(6);
    hh = h; mm = m; ss = s; pm = p; req = 1;
    step();
    req = 0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat, cnt, d;

  initial begin
    reset = 0; req = 0; pm = 0; hh = 8'h12; mm = 8'h00; ss = 8'h00;
    model_reset();
    repeat (3) step();
    check("reset_busy", int'(busy), 0);
    check("reset_sod",  int'(sod), 0);
    check("reset_hour", int'(hour24), 0);
    reset = 1;

    // midnight
    run_one(8'h12, 8'h00, 8'h00, 1'b0, lat);
    check("t1_lat", lat, 4);
    check("t1_hour", int'(hour24), 0);
    check("t1_sod", int'(sod), 0);
    check("t1_err", int'(err), 0);

    // last second of the day
    run_one(8'h11, 8'h59, 8'h59, 1'b1, lat);
    check("t2_lat", lat, 4);
    check("t2_hour", int'(hour24), 23);
    check("t2_min", int'(min), 59);
    check("t2_sec", int'(sec), 59);
    check("t2_sod", int'(sod), 86399);

    // just after noon
    run_one(8'h12, 8'h30, 8'h15, 1'b1, lat);
    check("t3_hour", int'(hour24), 12);
    check("t3_sod", int'(sod), 45015);

    // invalid snapshots
    run_one(8'h13, 8'h10, 8'h10, 1'b0, lat);
    check("t4a_lat", lat, 1);
    check("t4a_err", int'(err), 1);
    check("t4a_sod", int'(sod), 0);
    run_one(8'h05, 8'h10, 8'h5A, 1'b0, lat);
    check("t4b_lat", lat, 1);
    check("t4b_err", int'(err), 1);
    run_one(8'h05, 8'h20, 8'h00, 1'b1, lat);
    check("t4v_err", int'(err), 0);
    check("t4v_sod", int'(sod), 62400);
    run_one(8'h00, 8'h10, 8'h10, 1'b0, lat);
    check("t4c_lat", lat, 1);
    check("t4c_err", int'(err), 1);
    check("t4c_hour", int'(hour24), 0);

    // request pulses while busy are dropped
    idle(6);
    set_time(3723); req = 1; step();
    req = 0; step();
    req = 1; step();
    req = 0; step();
    req = 1; step();
    req = 0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) cnt++;
    end
    check("t5_busy_req_done_cnt", cnt, 0);

    // req held high on a running clock that crosses midnight
    idle(6);
    d = 86395;
    cnt = 0;
    req = 1;
    for (int i = 0; i < 20; i++) begin
      set_time(d);
      d = (d + 1) % 86400;
      step();
      if (done) cnt++;
    end
    req = 0;
    check("t5_held_done_cnt", cnt, 4);

    // held req with an invalid bus repeats every 2 cycles
    idle(6);
    hh = 8'h1F; req = 1; cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done) cnt++;
    end
    req = 0;
    check("t5_err_done_cnt", cnt, 5);

    // reset in the middle of a conversion
    run_one(8'h12, 8'h30, 8'h15, 1'b1, lat);
    idle(3);
    hh = 8'h09; mm = 8'h45; ss = 8'h30; pm = 0; req = 1;
    step();
    req = 0;
    repeat (3) step();
    reset = 0;
    model_reset();
    #1;
    check("t6_busy", int'(busy), 0);
    check("t6_done", int'(done), 0);
    check("t6_sod", int'(sod), 0);
    step();
    step();
    reset = 1;
    run_one(8'h09, 8'h45, 8'h30, 1'b0, lat);
    check("t6_lat", lat, 4);
    check("t6_sod_after", int'(sod), 35130);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      req = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 4) != 0) begin
        set_time(int'($urandom_range(0, 86399)));
      end else begin
        hh = 8'($urandom); mm = 8'($urandom); ss = 8'($urandom);
        pm = 1'($urandom);
      end
      step();
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
